rt_ibex_pcs_restore_seq: RTL and testbench

- Downstream consumer of the preemptive-context-save (PCS) LIFO.
- On the LIFO's one-cycle restore strobe, captures the parallel bundle of saved caller-saved registers and writes it back into the register file. Writes go out serially, one register per cycle, through a shared write port.
- Stalls the pipeline until the restore completes so the interrupted context resumes with correct register state.

---
 rtl/rt_ibex_pcs_pkg.sv | 25 ++
 rtl/rt_ibex_pcs_restore_seq.sv | 114 +++++++++++
 tb/tb_rt_ibex_pcs_restore_seq.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rt_ibex_pcs_pkg.sv
// rtl/rt_ibex_pcs_pkg.sv - shared types and register map for the PCS store/restore path
//
// Purpose: restore FSM state type, the number of saved registers, and the
//          bundle-index -> register-address table. The store side packs its
//          bundle with the same table, so entry i always means the same register.
// Ports:   none (package).
package rt_ibex_pcs_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } pcs_restore_state_t;

  localparam int PcsNrSavedRegs  = 9;
  localparam int PcsMaxSavedRegs = 16;

  // Entry 0 is the rightmost element: x1, x5, x6, x7, x10..x14 cover the
  // default bundle. Entries 9..15 extend the order for larger bundles.
  localparam logic [PcsMaxSavedRegs-1:0][4:0] PcsRegAddr = {
    5'd31, 5'd30, 5'd29, 5'd28, 5'd17, 5'd16, 5'd15,
    5'd14, 5'd13, 5'd12, 5'd11, 5'd10, 5'd7, 5'd6, 5'd5, 5'd1
  };

endpackage

// File: rtl/rt_ibex_pcs_restore_seq.sv
// rtl/rt_ibex_pcs_restore_seq.sv - serial register-file restore of a PCS bundle
//
// Purpose: captures the saved-register bundle on the LIFO restore strobe and
//          writes it back to the register file one register per granted cycle.
//          The pipeline is stalled for the whole sequence.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   restore_en_i             one-cycle restore strobe
//   restore_data_i           packed bundle, entry i -> PcsRegAddr[i]
//   rf_we_o/waddr_o/wdata_o  register-file write request
//   rf_wgnt_i                write port granted this cycle
//   busy_o                   pipeline stall request
//   done_o                   one-cycle pulse after the last write
//   overrun_o                sticky: strobe arrived while not idle
//   overrun_clr_i            clears overrun_o (a simultaneous set wins)
module rt_ibex_pcs_restore_seq
  import rt_ibex_pcs_pkg::*;
#(
  parameter int NrSavedRegs  = PcsNrSavedRegs,
  parameter int DataWidth    = 32,
  parameter int RegAddrWidth = 5
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  restore_en_i,
  input  logic [NrSavedRegs-1:0][DataWidth-1:0] restore_data_i,
  output logic                                  rf_we_o,
  output logic [RegAddrWidth-1:0]               rf_waddr_o,
  output logic [DataWidth-1:0]                  rf_wdata_o,
  input  logic                                  rf_wgnt_i,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic                                  overrun_o,
  input  logic                                  overrun_clr_i
);

  localparam int IdxW = (NrSavedRegs > 1) ? $clog2(NrSavedRegs) : 1;

  pcs_restore_state_t                    r_state;
  pcs_restore_state_t                    w_state_next;
  logic [NrSavedRegs-1:0][DataWidth-1:0] r_buf;
  logic [IdxW-1:0]                       r_idx;
  logic                                  r_overrun;

  logic w_capture;
  logic w_last;
  logic w_advance;
  logic w_overrun_set;

  assign w_capture     = (r_state == IDLE) && restore_en_i;
  assign w_last        = (r_idx == IdxW'(NrSavedRegs - 1));
  // The index stops at the last entry; leaving WRITE is what ends the walk.
  assign w_advance     = (r_state == WRITE) && rf_wgnt_i && !w_last;
  assign w_overrun_set = (r_state != IDLE) && restore_en_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_buf     <= '0;
      r_idx     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_buf <= restore_data_i;
        r_idx <= '0;
      end else if (w_advance) begin
        r_idx <= r_idx + IdxW'(1);
      end
      if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr_i) begin
        r_overrun <= 1'b0;
      end
    end
  end

  // Write request depends only on registered state: a denied grant simply
  // leaves the same address/data presented next cycle.
  always_comb begin
    w_state_next = r_state;
    rf_we_o      = 1'b0;
    rf_waddr_o   = '0;
    rf_wdata_o   = '0;
    done_o       = 1'b0;
    case (r_state)
      IDLE: begin
        if (restore_en_i) begin
          w_state_next = WRITE;
        end
      end
      WRITE: begin
        rf_we_o    = 1'b1;
        rf_waddr_o = RegAddrWidth'(PcsRegAddr[r_idx]);
        rf_wdata_o = r_buf[r_idx];
        if (rf_wgnt_i && w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        done_o       = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Stall already in the strobe cycle so nothing reads stale registers.
  assign busy_o    = restore_en_i || (r_state != IDLE);
  assign overrun_o = r_overrun;

endmodule

// File: tb/tb_rt_ibex_pcs_restore_seq.sv
// tb/tb_rt_ibex_pcs_restore_seq.sv - self-checking bench for rt_ibex_pcs_restore_seq
module tb_rt_ibex_pcs_restore_seq;

  localparam int N  = 9;
  localparam int DW = 32;
  localparam int AW = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              restore_en;
  logic [N-1:0][DW-1:0] restore_data;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [DW-1:0]     rf_wdata;
  logic              rf_wgnt;
  logic              busy;
  logic              done;
  logic              overrun;
  logic              overrun_clr;

  int n_pass  = 0;
  int n_total = 0;

  logic [AW+DW-1:0] sb[$];
  int exp_addr[N] = '{1, 5, 6, 7, 10, 11, 12, 13, 14};

  always #5 clk = ~clk;

  rt_ibex_pcs_restore_seq #(
    .NrSavedRegs (N),
    .DataWidth   (DW),
    .RegAddrWidth(AW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .restore_en_i  (restore_en),
    .restore_data_i(restore_data),
    .rf_we_o       (rf_we),
    .rf_waddr_o    (rf_waddr),
    .rf_wdata_o    (rf_wdata),
    .rf_wgnt_i     (rf_wgnt),
    .busy_o        (busy),
    .done_o        (done),
    .overrun_o     (overrun),
    .overrun_clr_i (overrun_clr)
  );

  // Scoreboard: every granted write must match the next expected (addr, data).
  always @(negedge clk) begin
    if (rst_n && rf_we && rf_wgnt) begin
      logic [AW+DW-1:0] exp;
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected_write got addr=%0d data=%h want none", rf_waddr, rf_wdata);
      end else begin
        exp = sb.pop_front();
        if ({rf_waddr, rf_wdata} !== exp)
          $display("FAIL sb_write got addr=%0d data=%h want addr=%0d data=%h",
                   rf_waddr, rf_wdata, exp[AW+DW-1:DW], exp[DW-1:0]);
        else
          n_pass++;
      end
    end
  end

  function automatic void push_bundle(input logic [N-1:0][DW-1:0] b);
    for (int i = 0; i < N; i++) sb.push_back({AW'(exp_addr[i]), b[i]});
  endfunction

  function automatic logic [N-1:0][DW-1:0] rand_bundle();
    logic [N-1:0][DW-1:0] b;
    for (int i = 0; i < N; i++) b[i] = $urandom;
    return b;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; restore_en = 1'b0; restore_data = '0; rf_wgnt = 1'b1; overrun_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({rf_we, rf_waddr, rf_wdata, busy, done, overrun} !== '0)
      $display("FAIL reset_outputs got %h want 0", {rf_we, rf_waddr, rf_wdata, busy, done, overrun});
    else n_pass++;
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_total++;
      if (rf_we !== 1'b0 || busy !== 1'b0) $display("FAIL reset_idle got we=%b busy=%b want 0 0", rf_we, busy);
      else n_pass++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [N-1:0][DW-1:0] b;
    for (int i = 0; i < N; i++) b[i] = 32'hA000_0000 + i;
    for (int c = 0; c < 12; c++) begin
      restore_en = (c == 0); restore_data = b; rf_wgnt = 1'b1;
      if (c == 0) push_bundle(b);
      @(negedge clk);
      n_total++;
      if (busy !== (c <= 10)) $display("FAIL basic_busy c=%0d got %b want %b", c, busy, c <= 10);
      else n_pass++;
      n_total++;
      if (done !== (c == 10)) $display("FAIL basic_done c=%0d got %b want %b", c, done, c == 10);
      else n_pass++;
      @(posedge clk); #1;
    end
    restore_en = 1'b0;
    n_total++;
    if (sb.size() != 0) $display("FAIL basic_drain got %0d left want 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [N-1:0][DW-1:0] b = rand_bundle();
    for (int c = 0; c < 14; c++) begin
      restore_en = (c == 0); restore_data = b; rf_wgnt = !(c == 2 || c == 3);
      if (c == 0) push_bundle(b);
      @(negedge clk);
      if (c >= 2 && c <= 4) begin
        n_total++;
        if (rf_we !== 1'b1 || rf_waddr !== AW'(5) || rf_wdata !== b[1])
          $display("FAIL stall_hold c=%0d got we=%b addr=%0d data=%h want 1 5 %h", c, rf_we, rf_waddr, rf_wdata, b[1]);
        else n_pass++;
      end
      n_total++;
      if (done !== (c == 12)) $display("FAIL stall_done c=%0d got %b want %b", c, done, c == 12);
      else n_pass++;
      @(posedge clk); #1;
    end
    restore_en = 1'b0; rf_wgnt = 1'b1;
    n_total++;
    if (sb.size() != 0) $display("FAIL stall_drain got %0d left want 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_overrun();
    logic [N-1:0][DW-1:0] b1 = rand_bundle();
    logic [N-1:0][DW-1:0] b2 = rand_bundle();
    for (int c = 0; c < 13; c++) begin
      restore_en = (c == 0 || c == 4); restore_data = (c == 0) ? b1 : b2;
      rf_wgnt = 1'b1; overrun_clr = (c == 11);
      if (c == 0) push_bundle(b1);
      @(negedge clk);
      n_total++;
      if (overrun !== (c >= 5 && c <= 11))
        $display("FAIL overrun_flag c=%0d got %b want %b", c, overrun, c >= 5 && c <= 11);
      else n_pass++;
      n_total++;
      if (done !== (c == 10)) $display("FAIL overrun_done c=%0d got %b want %b", c, done, c == 10);
      else n_pass++;
      @(posedge clk); #1;
    end
    restore_en = 1'b0; overrun_clr = 1'b0;
  endtask

  task automatic test_collision();
    logic [N-1:0][DW-1:0] b = rand_bundle();
    for (int c = 0; c < 13; c++) begin
      restore_en = (c == 0 || c == 3); restore_data = b;
      rf_wgnt = 1'b1; overrun_clr = (c == 3 || c == 11);
      if (c == 0) push_bundle(b);
      @(negedge clk);
      n_total++;
      if (overrun !== (c >= 4 && c <= 11))
        $display("FAIL collision_flag c=%0d got %b want %b", c, overrun, c >= 4 && c <= 11);
      else n_pass++;
      @(posedge clk); #1;
    end
    restore_en = 1'b0; overrun_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [N-1:0][DW-1:0] b1 = rand_bundle();
    logic [N-1:0][DW-1:0] b2 = rand_bundle();
    for (int c = 0; c < 23; c++) begin
      restore_en = (c == 0 || c == 11); restore_data = (c < 11) ? b1 : b2; rf_wgnt = 1'b1;
      if (c == 0) push_bundle(b1);
      if (c == 11) push_bundle(b2);
      @(negedge clk);
      n_total++;
      if (done !== (c == 10 || c == 21)) $display("FAIL b2b_done c=%0d got %b want %b", c, done, c == 10 || c == 21);
      else n_pass++;
      n_total++;
      if (busy !== (c <= 21)) $display("FAIL b2b_busy c=%0d got %b want %b", c, busy, c <= 21);
      else n_pass++;
      n_total++;
      if (overrun !== 1'b0) $display("FAIL b2b_overrun c=%0d got %b want 0", c, overrun);
      else n_pass++;
      @(posedge clk); #1;
    end
    restore_en = 1'b0;
    n_total++;
    if (sb.size() != 0) $display("FAIL b2b_drain got %0d left want 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [N-1:0][DW-1:0] b = rand_bundle();
    for (int c = 0; c < 4; c++) begin
      restore_en = (c == 0 || c == 2); restore_data = b; rf_wgnt = 1'b1;
      if (c == 0) push_bundle(b);
      @(negedge clk);
      @(posedge clk); #1;
    end
    restore_en = 1'b0;
    n_total++;
    if (overrun !== 1'b1 || rf_we !== 1'b1) $display("FAIL mid_pre got ovr=%b we=%b want 1 1", overrun, rf_we);
    else n_pass++;
    n_total++;
    if (sb.size() != N - 3) $display("FAIL mid_progress got %0d left want %0d", sb.size(), N - 3);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({rf_we, rf_waddr, rf_wdata, busy, done, overrun} !== '0)
      $display("FAIL mid_reset_outputs got %h want 0", {rf_we, rf_waddr, rf_wdata, busy, done, overrun});
    else n_pass++;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_total++;
      if (rf_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
        $display("FAIL mid_post c=%0d got we=%b busy=%b done=%b want 0 0 0", c, rf_we, busy, done);
      else n_pass++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_overrun();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
